// File: rtl/even_parity_serial_tx_if.sv
// Parallel-word handshake and serial line bundle for the even-parity transmitter.
// The master side offers words; the slave side is the transmitter itself.
interface even_parity_serial_tx_if #(
    parameter int DATA_W = 4
) ();
    logic [DATA_W-1:0] in;
    logic              valid;
    logic              ready;
    logic              tx;
    logic              p;
    logic              busy;

    modport master (
        output in,
        output valid,
        input  ready,
        input  tx,
        input  p,
        input  busy
    );

    modport slave (
        input  in,
        input  valid,
        output ready,
        output tx,
        output p,
        output busy
    );
endinterface

// File: rtl/even_parity_serial_tx.sv
// Serial frame transmitter: start(0), DATA_W data bits LSB first, even parity, stop(1),
// each bit held BIT_CYCLES clocks. Words are taken over a valid/ready handshake.
module even_parity_serial_tx #(
    parameter int DATA_W     = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    even_parity_serial_tx_if.slave   bus
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cyc_reg, cyc_next;
    logic [BW-1:0]     bit_reg, bit_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              p_reg, p_next;
    logic              tx_reg, tx_next;
    logic              cyc_last;
    logic              bit_last;
    logic              accept;

    assign cyc_last = (cyc_reg == CW'(BIT_CYCLES - 1));
    assign bit_last = (bit_reg == BW'(DATA_W - 1));
    // ready is held low during reset so a word offered in the reset cycle is never taken
    assign bus.ready = (state_reg == IDLE) && !rst;
    assign accept    = bus.valid && bus.ready;
    assign bus.tx    = tx_reg;
    assign bus.p     = p_reg;
    assign bus.busy  = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cyc_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            p_reg     <= 1'b0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            p_reg     <= p_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        p_next     = p_reg;
        tx_next    = 1'b1;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = START;
                    shift_next = bus.in;
                    p_next     = ^bus.in;
                    cyc_next   = '0;
                    bit_next   = '0;
                end
            end
            START: begin
                if (cyc_last) begin
                    cyc_next   = '0;
                    state_next = DATA;
                end else begin
                    cyc_next = cyc_reg + 1'b1;
                end
            end
            DATA: begin
                if (cyc_last) begin
                    cyc_next   = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_last) begin
                        bit_next   = '0;
                        state_next = PARITY;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    cyc_next = cyc_reg + 1'b1;
                end
            end
            PARITY: begin
                if (cyc_last) begin
                    cyc_next   = '0;
                    state_next = STOP;
                end else begin
                    cyc_next = cyc_reg + 1'b1;
                end
            end
            STOP: begin
                if (cyc_last) begin
                    cyc_next   = '0;
                    state_next = IDLE;
                end else begin
                    cyc_next = cyc_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // tx is registered, so it is derived from where the machine is heading
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = p_next;
            default: tx_next = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Directed bench for even_parity_serial_tx: default 4-bit/4-cycle instance plus an
// 8-bit/1-cycle instance, each frame checked bit by bit against hand-written vectors.
module tb_even_parity_serial_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_accept = 0;

    even_parity_serial_tx_if #(.DATA_W(4)) b1 ();
    even_parity_serial_tx_if #(.DATA_W(8)) b2 ();

    even_parity_serial_tx #(.DATA_W(4), .BIT_CYCLES(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    even_parity_serial_tx #(.DATA_W(8), .BIT_CYCLES(1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (b1.valid && b1.ready) n_accept++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called one sample after the accept edge; checks all 28 bit cycles and the
    // first idle cycle. Optionally offers a stray word mid-frame.
    task automatic check_frame(input string tag, input logic [6:0] exp, input logic exp_p,
                               input bit stray);
        int k = 0;
        for (int b = 0; b < 7; b++) begin
            for (int c = 0; c < 4; c++) begin
                if (stray && k == 10) begin
                    b1.in    = 4'b1000;
                    b1.valid = 1'b1;
                end
                if (stray && k == 26) b1.valid = 1'b0;
                chk($sformatf("%s tx b%0d c%0d", tag, b, c), 32'(b1.tx), 32'(exp[b]));
                chk($sformatf("%s busy b%0d c%0d", tag, b, c), 32'(b1.busy), 32'd1);
                if (k == 5) chk({tag, " ready mid"}, 32'(b1.ready), 32'd0);
                k++;
                tick();
            end
        end
        chk({tag, " p"}, 32'(b1.p), 32'(exp_p));
        chk({tag, " idle tx"}, 32'(b1.tx), 32'd1);
        chk({tag, " idle busy"}, 32'(b1.busy), 32'd0);
        chk({tag, " idle ready"}, 32'(b1.ready), 32'd1);
    endtask

    initial begin
        logic [6:0]  recv;
        logic [10:0] exp11;
        int          acc_snap;

        b1.in = '0; b1.valid = 1'b0;
        b2.in = '0; b2.valid = 1'b0;
        #1;
        tick();
        tick();
        chk("reset ready", 32'(b1.ready), 32'd0);
        chk("reset tx", 32'(b1.tx), 32'd1);
        chk("reset busy", 32'(b1.busy), 32'd0);
        chk("reset p", 32'(b1.p), 32'd0);
        rst = 1'b0;
        tick();
        chk("post-reset ready", 32'(b1.ready), 32'd1);
        chk("post-reset tx", 32'(b1.tx), 32'd1);

        // single frame of 0001: 0,1,0,0,0,1,1
        b1.in = 4'b0001; b1.valid = 1'b1;
        tick();
        b1.valid = 1'b0;
        check_frame("f0001", 7'b1100010, 1'b1, 1'b0);
        $display("frame in=0001 checked");

        // back-to-back 0110 then 1111 with valid held
        acc_snap = n_accept;
        b1.in = 4'b0110; b1.valid = 1'b1;
        tick();
        b1.in = 4'b1111;
        check_frame("f0110", 7'b1001100, 1'b0, 1'b0);
        tick();
        check_frame("f1111", 7'b1011110, 1'b0, 1'b0);
        b1.valid = 1'b0;
        tick();
        chk("b2b accepts", 32'(n_accept - acc_snap), 32'd2);
        $display("frames in=0110,1111 back-to-back checked");

        // sweep every word, recovering bits mid-period like the far-end checker would
        for (int v = 0; v < 16; v++) begin
            b1.in = 4'(v); b1.valid = 1'b1;
            tick();
            b1.valid = 1'b0;
            for (int b = 0; b < 7; b++) begin
                for (int c = 0; c < 4; c++) begin
                    if (c == 2) recv[b] = b1.tx;
                    tick();
                end
            end
            chk($sformatf("sweep %0d start", v), 32'(recv[0]), 32'd0);
            chk($sformatf("sweep %0d data", v), 32'(recv[4:1]), 32'(v));
            chk($sformatf("sweep %0d even", v), 32'(^recv[5:1]), 32'd0);
            chk($sformatf("sweep %0d stop", v), 32'(recv[6]), 32'd1);
            chk($sformatf("sweep %0d p", v), 32'(b1.p), 32'(recv[5]));
            $display("sweep in=%0d recovered=%0d parity=%0b", v, recv[4:1], recv[5]);
        end
        tick();

        // stray valid mid-frame must be ignored
        acc_snap = n_accept;
        b1.in = 4'b0101; b1.valid = 1'b1;
        tick();
        b1.valid = 1'b0;
        check_frame("f0101", 7'b1001010, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stray idle tx %0d", i), 32'(b1.tx), 32'd1);
            tick();
        end
        chk("stray accepts", 32'(n_accept - acc_snap), 32'd1);
        chk("stray p held", 32'(b1.p), 32'd0);
        $display("stray valid mid-frame checked");

        // reset in the middle of the data bits of 1010
        b1.in = 4'b1010; b1.valid = 1'b1;
        tick();
        b1.valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("pre-abort busy", 32'(b1.busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("abort tx", 32'(b1.tx), 32'd1);
        chk("abort busy", 32'(b1.busy), 32'd0);
        chk("abort ready", 32'(b1.ready), 32'd0);
        tick();
        chk("abort ready hold", 32'(b1.ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort ready release", 32'(b1.ready), 32'd1);
        b1.in = 4'b1010; b1.valid = 1'b1;
        tick();
        b1.valid = 1'b0;
        check_frame("f1010", 7'b1010100, 1'b0, 1'b0);
        $display("mid-frame reset and recovery checked");

        // 8-bit word, one cycle per bit: 0,1,0,1,0,0,1,0,1,0,1
        exp11 = 11'b10101001010;
        b2.in = 8'hA5; b2.valid = 1'b1;
        tick();
        b2.valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("a5 tx %0d", i), 32'(b2.tx), 32'(exp11[i]));
            chk($sformatf("a5 busy %0d", i), 32'(b2.busy), 32'd1);
            tick();
        end
        chk("a5 p", 32'(b2.p), 32'd0);
        chk("a5 idle busy", 32'(b2.busy), 32'd0);
        chk("a5 idle ready", 32'(b2.ready), 32'd1);
        chk("a5 idle tx", 32'(b2.tx), 32'd1);
        $display("frame in=A5 (8 bit, 1 cycle/bit) checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/even_parity_serial_tx.md
# even_parity_serial_tx

Serial frame transmitter that produces even-parity-protected words for the even parity checker at the far end of the link. It accepts a parallel data word through a valid/ready handshake, computes its even parity bit, and shifts out a framed word at a fixed bit period: start, data LSB first, parity, stop. It sits on the send side of the serial link, and its frame layout is the one the receive side checks.

## Interface
- DATA_W, 4: data word width in bits (≥1).
- BIT_CYCLES, 4: clock cycles per serial bit (≥1).

- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  DATA_W  parallel data word; sampled only on accept.
- valid  input  1  word on `in` is offered.
- ready  output  1  transmitter can accept a word this cycle.
- tx  output  1  serial line; idles high.
- p  output  1  even parity bit of the word in flight (XOR of all its bits).
- busy  output  1  a frame is being shifted out.

## Operation
- Frame: 1 start bit (0), DATA_W data bits LSB first, 1 parity bit (= ^data, so the total number of ones in data+parity is even), 1 stop bit (1).
- Frame length is (DATA_W+3)*BIT_CYCLES cycles.
- States and transitions:
  - IDLE → START on accept.
  - START → DATA after BIT_CYCLES cycles.
  - DATA → PARITY after DATA_W bits.
  - PARITY → STOP after BIT_CYCLES cycles.
  - STOP → IDLE after BIT_CYCLES cycles.
- Accept = valid && ready at a rising edge. On accept: the shift register loads `in`, `p` loads ^in, and the bit counter and cycle counter clear.
- ready = 1 only in IDLE. A valid asserted while ready=0 is ignored; there is no buffering. The source must hold the word until accepted.
- `in` changes after accept do not affect the frame in flight.
- tx is a registered output:
  - IDLE: 1.
  - START: 0.
  - DATA: current shift-register LSB; shifts right once per BIT_CYCLES.
  - PARITY: p.
  - STOP: 1.
- busy = 1 in START, DATA, PARITY and STOP.
- p holds its value after the frame until the next accept.
- Counters:
  - Cycle counter is $clog2(BIT_CYCLES)-bit min 1; it wraps from BIT_CYCLES-1 to 0 and advances the bit.
  - Bit counter is $clog2(DATA_W)-bit min 1; it counts 0..DATA_W-1.
- Reset values: tx=1, ready=1 (from the first cycle after rst deasserts; ready=0 while rst=1), busy=0, p=0, state IDLE, counters 0.
- Reset mid-frame aborts immediately. tx=1, busy=0 after that edge. The partial frame is not resumed.
- valid high during the rst cycle is not accepted.

## Timing
- Accept at edge E: at E+1, tx=0 and busy=1.
- Start bit occupies E+1 .. E+BIT_CYCLES.
- Data bit i occupies edges E+1+(1+i)*BIT_CYCLES for BIT_CYCLES cycles.
- Parity bit starts at E+1+(1+DATA_W)*BIT_CYCLES.
- Stop bit starts at E+1+(2+DATA_W)*BIT_CYCLES.
- At E+1+(3+DATA_W)*BIT_CYCLES: state IDLE, busy=0, ready=1, tx=1.
- Back-to-back (valid held high): the next accept is on the first IDLE cycle. This gives exactly one idle tx=1 cycle between the stop bit and the next start bit. Frame period is (DATA_W+3)*BIT_CYCLES+1 cycles.
- BIT_CYCLES=1: every bit lasts one cycle, with no special-casing.

## Test plan
- Defaults, in=4'b0001, valid pulse → tx sequence per bit 0,1,0,0,0,1,1, each held 4 cycles; p=1; busy high 28 cycles; ready returns high at accept+29.
- in=4'b0110 then 4'b1111 with valid held → parity bits 0 and 0; frames 0,0,1,1,0,0,1 and 0,1,1,1,1,0,1; exactly one idle cycle between frames; only two accepts.
- Sweep in=0..15 with an inline checker model → recovered data equals in and ones(data)+parity is even for every word (e.g. 4'b1011 → p=1).
- valid asserted mid-frame with in=4'b1000, dropped before IDLE → no accept, frame unchanged, tx stays 1 afterward.
- rst asserted during DATA of in=4'b1010 → next cycle tx=1, busy=0, ready=0 while rst is high, ready=1 after deassert; a new frame then transmits cleanly.
- BIT_CYCLES=1, DATA_W=8, in=8'hA5 → 11-cycle frame 0,1,0,1,0,0,1,0,1,0,1; p=0.
